// File: rtl/note_tone_gen_pkg.sv
// note_tone_gen shared types and constants.
// State encoding, sample midscale and ROM bus widths.
package note_tone_gen_pkg;
  localparam int IDX_W = 5;
  localparam int PER_W = 8;
  localparam logic [7:0] MIDSCALE = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } state_t;
endpackage

// File: rtl/tone_phase_ctr.sv
// Half-period counter and square-wave phase for note_tone_gen.
// A latched period of 0 behaves as 256 via 8-bit wrap of half_per-1.
module tone_phase_ctr
  import note_tone_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [PER_W-1:0] rom_d,
  output logic             phase
);

  logic [PER_W-1:0] half_per;
  logic [PER_W-1:0] phase_cnt;
  logic             wrap;

  assign wrap = phase_cnt == (half_per - PER_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_per  <= '0;
      phase_cnt <= '0;
      phase     <= 1'b0;
    end else if (load) begin
      half_per  <= rom_d;
      phase_cnt <= '0;
      phase     <= 1'b1;
    end else if (en) begin
      if (wrap) begin
        phase_cnt <= '0;
        phase     <= ~phase;
      end else begin
        phase_cnt <= phase_cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator fed by the note-to-period ROM.
// Optional amplitude decay is built when TONE_DECAY_EN is defined.
module note_tone_gen
  import note_tone_gen_pkg::*;
#(
  parameter int AMP_INIT = 100,
  parameter int DUR_W    = 16
`ifdef TONE_DECAY_EN
  ,
  parameter int DECAY_DIV = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [IDX_W-1:0] note_i,
  input  logic [DUR_W-1:0] dur,
  output logic [IDX_W-1:0] rom_i,
  input  logic [PER_W-1:0] rom_d,
  output logic [7:0]       sample,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic             done_nxt;
  logic             accept;
  logic             play_tick;
  logic             phase;
  logic [DUR_W-1:0] dur_cnt;
  logic [7:0]       amp;

  assign note_ready = (state == IDLE) && rst_n;
  assign accept     = note_valid && note_ready;
  assign busy       = state != IDLE;
  assign play_tick  = (state == PLAY) && tick;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: begin
        if (dur_cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (tick && dur_cnt == DUR_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_i   <= '0;
      dur_cnt <= '0;
    end else if (accept) begin
      rom_i   <= note_i;
      dur_cnt <= dur;
    end else if (play_tick) begin
      dur_cnt <= dur_cnt - DUR_W'(1);
    end
  end

`ifdef TONE_DECAY_EN
  localparam int DCW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  logic [DCW-1:0] decay_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decay_cnt <= '0;
      amp       <= '0;
    end else if (state == LOAD) begin
      decay_cnt <= '0;
      amp       <= 8'(AMP_INIT);
    end else if (play_tick) begin
      if (decay_cnt == DCW'(DECAY_DIV - 1)) begin
        decay_cnt <= '0;
        if (amp != 8'd0) amp <= amp - 8'd1;
      end else begin
        decay_cnt <= decay_cnt + DCW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) amp <= '0;
    else if (state == LOAD) amp <= 8'(AMP_INIT);
  end
`endif

  tone_phase_ctr u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == LOAD),
    .en    (play_tick),
    .rom_d (rom_d),
    .phase (phase)
  );

  assign sample = (state != PLAY) ? MIDSCALE :
                  phase ? MIDSCALE + amp : MIDSCALE - amp;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen (default build, AMP_INIT=100).
// Note table plus hand sequences for busy requests and mid-note reset.
module tb_note_tone_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [4:0]  note_i = '0;
  logic [15:0] dur = '0;
  logic [4:0]  rom_i;
  logic [7:0]  rom_d;
  logic [7:0]  sample;
  logic        busy;
  logic        done;

  int nvec = 0;
  int nerr = 0;

  note_tone_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_i     (note_i),
    .dur        (dur),
    .rom_i      (rom_i),
    .rom_d      (rom_d),
    .sample     (sample),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_d = 8'd50;
    case (rom_i)
      5'd0:  rom_d = 8'd128;
      5'd31: rom_d = 8'd21;
      5'd5:  rom_d = 8'd0;
      5'd7:  rom_d = 8'd1;
      default: rom_d = 8'd50;
    endcase
  end

  typedef struct {
    string name;
    int    note;
    int    dur;
    int    gap;
    int    hp;
    int    tog;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic play_note(input vec_t v);
    int  consumed;
    int  toggles;
    int  prev;
    int  exp;
    int  limit;
    bit  fin;
    consumed = 0;
    toggles  = 0;
    prev     = 228;
    fin      = 1'b0;
    limit    = v.dur * v.gap + 2 * v.gap + 4;
    note_valid = 1'b1;
    note_i     = 5'(v.note);
    dur        = 16'(v.dur);
    tick       = (v.gap == 1);
    @(posedge clk);
    @(negedge clk);
    note_valid = 1'b0;
    chk({v.name, " load_busy"}, int'(busy), 1);
    chk({v.name, " load_rdy"}, int'(note_ready), 0);
    chk({v.name, " load_smp"}, int'(sample), 128);
    chk({v.name, " load_romi"}, int'(rom_i), v.note);
    for (int c = 0; c < limit && !fin; c++) begin
      tick = (v.gap == 1) ? 1'b1 : ((c % v.gap) == v.gap - 1);
      @(posedge clk);
      if (c >= 1 && tick) consumed++;
      @(negedge clk);
      if (done) begin
        fin = 1'b1;
        chk({v.name, " end_smp"}, int'(sample), 128);
        chk({v.name, " end_busy"}, int'(busy), 0);
        chk({v.name, " end_rdy"}, int'(note_ready), 1);
      end else begin
        exp = ((consumed / v.hp) % 2 == 0) ? 228 : 28;
        chk({v.name, " smp"}, int'(sample), exp);
        if (int'(sample) != prev) toggles++;
        prev = int'(sample);
      end
    end
    tick = 1'b0;
    chk({v.name, " done_seen"}, int'(fin), 1);
    chk({v.name, " ticks"}, consumed, v.dur);
    chk({v.name, " toggles"}, toggles, v.tog);
    @(posedge clk);
    @(negedge clk);
    chk({v.name, " done_fall"}, int'(done), 0);
  endtask

  initial begin
    int  edges;
    bit  fin;

    vecs[0] = '{"basic",   0, 512,    1, 128, 3};
    vecs[1] = '{"high",   31,  42, 1000,  21, 1};
    vecs[2] = '{"zero",    3,   0,    1,  50, 0};
    vecs[3] = '{"per256",  5, 300,    1, 256, 1};
    vecs[4] = '{"per1",    7,   5,    1,   1, 4};
    vecs[5] = '{"one",     9,   1,    3,  50, 0};

    #2;
    chk("rst_smp", int'(sample), 128);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_romi", int'(rom_i), 0);
    chk("rst_rdy", int'(note_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", int'(note_ready), 1);

    for (int i = 0; i < 6; i++) play_note(vecs[i]);

    // request held high while a note plays
    note_valid = 1'b1;
    note_i     = 5'd2;
    dur        = 16'd20;
    tick       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    note_i = 5'd4;
    dur    = 16'd3;
    fin    = 1'b0;
    edges  = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) begin
        fin = 1'b1;
      end else begin
        chk("hold_rdy", int'(note_ready), 0);
        chk("hold_romi", int'(rom_i), 2);
      end
    end
    chk("hold_done", int'(fin), 1);
    chk("hold_edges", edges, 21);
    chk("hold_rdy_end", int'(note_ready), 1);
    chk("hold_romi_end", int'(rom_i), 2);
    @(posedge clk);
    @(negedge clk);
    note_valid = 1'b0;
    chk("second_romi", int'(rom_i), 4);
    chk("second_busy", int'(busy), 1);
    chk("second_done", int'(done), 0);
    fin   = 1'b0;
    edges = 0;
    for (int c = 0; c < 10 && !fin; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) fin = 1'b1;
    end
    chk("second_fin", int'(fin), 1);
    chk("second_edges", edges, 4);
    tick = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of a note
    note_valid = 1'b1;
    note_i     = 5'd0;
    dur        = 16'd512;
    tick       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    note_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_smp", int'(sample), 128);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_romi", int'(rom_i), 0);
    chk("arst_rdy", int'(note_ready), 0);
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rdy_rel", int'(note_ready), 1);
    play_note('{"after_rst", 31, 10, 1, 21, 0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Tone generator that sits directly downstream of the note-to-period ROM in the drum/piano machine. It accepts a note request (5-bit note index plus duration), drives the index into the ROM, and latches the returned 8-bit half-period count. It then produces an 8-bit unsigned square-wave audio sample for the requested number of 50 kHz sample ticks, after which it signals completion.

## Interface
- AMP_INIT, 100: initial square-wave amplitude about midscale; legal range 0..127.
- DUR_W, 16: width of the duration field, in ticks.
- DECAY_DIV, 64: number of ticks per amplitude decrement; used only when decay is compiled in; legal range ≥1.
- CLK  in  1  system clock.
- RST_N  in  1  reset; one clock; asynchronous, active-low.
- TICK  in  1  50 kHz sample-rate enable, one CLK wide.
- NOTE_VALID  in  1  request valid.
- NOTE_READY  out  1  request accepted when NOTE_VALID & NOTE_READY are both high at a CLK edge.
- NOTE_I  in  5  note index.
- DUR  in  DUR_W  note length in TICKs.
- ROM_I  out  5  index to the period ROM.
- ROM_D  in  8  half-period from the ROM, combinational.
- SAMPLE  out  8  unsigned audio sample; midscale is 128.
- BUSY  out  1  high in LOAD and PLAY.
- DONE  out  1  one-CLK pulse at the end of a note.

## Operation
- The state machine has three states: IDLE, LOAD and PLAY.
- **IDLE:** NOTE_READY=1 and SAMPLE=128.
  - On accept, NOTE_I is captured into the ROM_I register and DUR into dur_cnt.
  - The next state is LOAD.
- **LOAD:** lasts one CLK.
  - ROM_D is latched into half_per. A value of 0 is treated as 256.
  - phase_cnt←0, phase←1, amp←AMP_INIT.
  - If dur_cnt==0, the block returns to IDLE and pulses DONE. Otherwise the next state is PLAY.
  - TICK is ignored in LOAD.
- **PLAY:** on each TICK:
  - dur_cnt decrements.
  - phase_cnt increments. When phase_cnt reaches half_per−1 it wraps to 0 and phase toggles.
- **End of note:** on the TICK that takes dur_cnt to 0, the next state is IDLE, DONE=1 for that one cycle, and SAMPLE returns to 128.
- **SAMPLE value:**
  - In PLAY: 128+amp when phase=1, 128−amp when phase=0. All arithmetic is 8-bit unsigned, and AMP_INIT≤127 guarantees there is no overflow.
  - Outside PLAY: 128.
- **Requests while busy:** NOTE_READY=0 in LOAD and PLAY, so requests are held off. The block does not support retrigger or abort.
- **ROM_I:** holds the last accepted index and never changes outside an accept.
- **Reset:** RST_N low at any point, including mid-note, immediately forces the following:
  - state=IDLE, NOTE_READY=1 (only after RST_N is released, i.e. high), BUSY=0, DONE=0, SAMPLE=128, ROM_I=0.
  - All counters are 0 and amp=0.

## Timing
- Accept at edge k → LOAD during cycle k..k+1 → PLAY from edge k+1.
- SAMPLE=128+AMP_INIT is visible after edge k+1.
- The first toggle occurs on the TICK that completes half_per ticks in PLAY.
- PLAY consumes exactly DUR TICKs. DONE rises on the edge that consumes the DUR-th TICK, and NOTE_READY=1 from that same edge.
- A new request can therefore be accepted on the edge after DONE rises, which is the edge where DONE falls.
- TICK and a state change never conflict, because TICK is sampled only in PLAY.
- Back-to-back TICKs (TICK held high) are legal, and each cycle counts as one tick.

## Configuration
- **TONE_DECAY_EN defined:** in PLAY, a decay_cnt counts TICKs.
  - Every DECAY_DIV TICKs, amp decrements by 1, saturating at 0.
  - decay_cnt is cleared in LOAD.
- **TONE_DECAY_EN undefined:** amp stays at AMP_INIT for the whole note, and there is no decay counter.

## Structure
- A shared package holds:
  - the state enum (IDLE/LOAD/PLAY);
  - MIDSCALE=8'd128;
  - the ROM index width (5) and period width (8).
- One sub-module is natural: tone_phase_ctr, which contains phase_cnt, half_per compare, and phase toggle, enabled by TICK & PLAY.
- Duration, decay and FSM logic live in the top module.
- The period ROM is instantiated outside this block and connected through ROM_I/ROM_D.

## Test plan
- **Basic note:** NOTE_I=0 (ROM 128), DUR=512, TICK every CLK → SAMPLE alternates 228/28 every 128 ticks, 4 half-periods in total. DONE pulses once on the 512th tick, then SAMPLE=128.
- **Highest note, gapped TICK:** NOTE_I=31 (ROM 21), DUR=42, TICK every 1000 CLK → exactly 2 half-periods of 21 ticks each. BUSY is high for 42 TICKs plus 1 cycle.
- **Zero duration:** DUR=0 → LOAD, then DONE on the next edge, no PLAY cycle, SAMPLE stays 128.
- **Requests while busy:** NOTE_VALID held high during PLAY → NOTE_READY=0 with no capture. The second note is accepted on the edge after DONE, and ROM_I changes only then.
- **Reset mid-note:** RST_N pulsed low mid-PLAY → all outputs go to reset values asynchronously. After release, a new note plays normally from phase=1.
- **Decay (TONE_DECAY_EN, DECAY_DIV=4, AMP_INIT=3, DUR=20):** amp steps 3→2→1→0 at ticks 4, 8 and 12. SAMPLE stays 128 from tick 12 onward.
